mul_unit: RTL and testbench

Parametrised iterative multiply / multiply-accumulate unit that sits beside the ALU in the multicycle ARM datapath. It executes MUL, MLA, UMULL and SMULL over a configurable operand width using a fixed-latency radix-2 shift-add sequencer. It talks to the controller through a Start/Busy/Done handshake. The controller stalls its FSM on Busy and writes ResultLo/ResultHi back through the result path when Done is high.

---
 rtl/mul_unit.sv | 141 ++++++++++++++
 tb/tb_mul_unit.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_unit.sv
// Iterative radix-2 shift-add multiplier for MUL/MLA/UMULL/SMULL with a Start/Busy/Done handshake.
// Fixed WIDTH+2 edge latency; results and flags are written only in the FIX cycle.
module mul_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [1:0]       Mode,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [WIDTH-1:0] AccIn,
  output logic [WIDTH-1:0] ResultLo,
  output logic [WIDTH-1:0] ResultHi,
  output logic [1:0]       MulFlags,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] M_MUL = 2'b00, M_MLA = 2'b01, M_SMULL = 2'b11;
  localparam logic [CW-1:0]      CNT_INIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0]      ONE_C    = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [1:0]         mode_q, mode_d;
  logic [1:0]         flags_q, flags_d;
  logic               sign_q, sign_d;

  logic               accept;
  logic               smull_in;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     add_sum;
  logic [2*WIDTH-1:0] full;

  assign accept   = Start && (state_q == IDLE || state_q == DONE);
  assign smull_in = (Mode == M_SMULL);
  // Two's-complement negate maps -2^(W-1) onto 2^(W-1), which is exact as unsigned.
  assign mag_a    = (smull_in && SrcA[WIDTH-1]) ? (~SrcA + ONE_W) : SrcA;
  assign mag_b    = (smull_in && SrcB[WIDTH-1]) ? (~SrcB + ONE_W) : SrcB;

  // Upper half keeps its carry-out so the right shift never loses a product bit.
  assign add_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (prod_q[0] ? mcand_q : {WIDTH{1'b0}})};
  assign full     = (mode_q == M_SMULL && sign_q) ? (~prod_q + ONE_2W) : prod_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    mode_d  = mode_q;
    sign_d  = sign_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    flags_d = flags_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          mode_d  = Mode;
          mcand_d = mag_a;
          acc_d   = AccIn;
          sign_d  = smull_in && (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
          prod_d  = {{WIDTH{1'b0}}, mag_b};
          cnt_d   = CNT_INIT;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        prod_d = {add_sum, prod_q[WIDTH-1:1]};
        if (cnt_q == '0) state_d = FIX;
        else             cnt_d   = cnt_q - ONE_C;
      end
      FIX: begin
        case (mode_q)
          M_MUL: begin
            lo_d = full[WIDTH-1:0];
            hi_d = '0;
          end
          M_MLA: begin
            lo_d = full[WIDTH-1:0] + acc_q;
            hi_d = '0;
          end
          default: begin
            lo_d = full[WIDTH-1:0];
            hi_d = full[2*WIDTH-1:WIDTH];
          end
        endcase
        if (mode_q[1]) flags_d = {hi_d[WIDTH-1], ({hi_d, lo_d} == '0)};
        else           flags_d = {lo_d[WIDTH-1], (lo_d == '0)};
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prod_q  <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      mode_q  <= '0;
      sign_q  <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      mode_q  <= mode_d;
      sign_q  <= sign_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      flags_q <= flags_d;
    end
  end

  assign ResultLo = lo_q;
  assign ResultHi = hi_q;
  assign MulFlags = flags_q;
  assign Busy     = (state_q == RUN) || (state_q == FIX);
  assign Done     = (state_q == DONE);

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: directed cases plus randomized ops against an arithmetic model,
// on a WIDTH=32 instance and a WIDTH=8 instance sharing clock and reset.
module tb_mul_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [1:0]  Mode;
  logic [31:0] SrcA, SrcB, AccIn;
  logic [31:0] ResultLo, ResultHi;
  logic [1:0]  MulFlags;
  logic        Busy, Done;

  logic        s8_Start;
  logic [1:0]  s8_Mode;
  logic [7:0]  s8_A, s8_B, s8_C, s8_Lo, s8_Hi;
  logic [1:0]  s8_Fl;
  logic        s8_Busy, s8_Done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .Start(Start), .Mode(Mode),
    .SrcA(SrcA), .SrcB(SrcB), .AccIn(AccIn),
    .ResultLo(ResultLo), .ResultHi(ResultHi), .MulFlags(MulFlags),
    .Busy(Busy), .Done(Done)
  );

  mul_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .Start(s8_Start), .Mode(s8_Mode),
    .SrcA(s8_A), .SrcB(s8_B), .AccIn(s8_C),
    .ResultLo(s8_Lo), .ResultHi(s8_Hi), .MulFlags(s8_Fl),
    .Busy(s8_Busy), .Done(s8_Done)
  );

  // Reference: plain wide arithmetic on the operands as integers.
  function automatic void model32(input logic [1:0] m, input logic [31:0] a, b, c,
                                  output logic [31:0] lo, output logic [31:0] hi,
                                  output logic [1:0] fl);
    logic [63:0] ua, ub, p;
    longint sa, sb, sp;
    ua = {32'b0, a};
    ub = {32'b0, b};
    p  = ua * ub;
    sa = $signed(a);
    sb = $signed(b);
    sp = sa * sb;
    case (m)
      2'b00:   begin lo = p[31:0];     hi = '0; end
      2'b01:   begin lo = p[31:0] + c; hi = '0; end
      2'b10:   begin lo = p[31:0];     hi = p[63:32]; end
      default: begin lo = sp[31:0];    hi = sp[63:32]; end
    endcase
    if (m[1]) fl = {hi[31], ({hi, lo} == 64'd0)};
    else      fl = {lo[31], (lo == 32'd0)};
  endfunction

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 6))
      0:       pick32 = 32'h0;
      1:       pick32 = 32'h1;
      2:       pick32 = 32'hFFFFFFFF;
      3:       pick32 = 32'h80000000;
      4:       pick32 = 32'h7FFFFFFF;
      default: pick32 = $urandom;
    endcase
  endfunction

  // Presents an op, consumes the accepting edge E0, then scrambles the now don't-care inputs.
  task automatic issue(input logic [1:0] m, input logic [31:0] a, b, c);
    @(negedge clk);
    Start = 1'b1; Mode = m; SrcA = a; SrcB = b; AccIn = c;
    @(posedge clk);
    #1;
    Start = 1'b0;
    Mode  = 2'($urandom_range(0, 3));
    SrcA  = $urandom; SrcB = $urandom; AccIn = $urandom;
  endtask

  // Counts edges after E0 until Done; hs_ok drops if Busy/Done ever misbehave on the way.
  task automatic wait_done(output int lat, output bit hs_ok);
    lat   = -1;
    hs_ok = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk);
      #1;
      if (Done && Busy) hs_ok = 1'b0;
      if (Done) begin
        lat = k;
        break;
      end else if (!Busy) hs_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; Start = 1'b0; Mode = '0; SrcA = '0; SrcB = '0; AccIn = '0;
    s8_Start = 1'b0; s8_Mode = '0; s8_A = '0; s8_B = '0; s8_C = '0;
    #1 reset = 1'b0;
    #2;
    checks++;
    if ({ResultLo, ResultHi, MulFlags, Busy, Done} !== 68'd0) begin
      errors++; $display("FAIL reset_outputs: got lo=%h hi=%h fl=%b busy=%b done=%b expected all 0",
                         ResultLo, ResultHi, MulFlags, Busy, Done);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({Busy, Done, s8_Busy, s8_Done} !== 4'b0) begin
      errors++; $display("FAIL reset_idle: got busy=%b done=%b busy8=%b done8=%b expected 0",
                         Busy, Done, s8_Busy, s8_Done);
    end
  endtask

  task automatic test_mul();
    int lat; bit ok;
    issue(2'b00, 32'd7, 32'd6, 32'd0);
    wait_done(lat, ok);
    checks++; if (lat !== 33) begin errors++; $display("FAIL mul_latency: got %0d expected 33", lat); end
    checks++; if (!ok) begin errors++; $display("FAIL mul_handshake: got busy/done violation expected clean"); end
    checks++; if (ResultLo !== 32'h2A) begin errors++; $display("FAIL mul_lo: got %h expected 0000002a", ResultLo); end
    checks++; if (ResultHi !== 32'h0) begin errors++; $display("FAIL mul_hi: got %h expected 0", ResultHi); end
    checks++; if (MulFlags !== 2'b00) begin errors++; $display("FAIL mul_flags: got %b expected 00", MulFlags); end
    @(posedge clk); #1;
    checks++; if (Done !== 1'b0 || Busy !== 1'b0) begin
      errors++; $display("FAIL mul_done_pulse: got done=%b busy=%b expected 0 0", Done, Busy);
    end
    checks++; if (ResultLo !== 32'h2A) begin errors++; $display("FAIL mul_hold: got %h expected 0000002a", ResultLo); end
  endtask

  task automatic test_mla();
    int lat; bit ok;
    issue(2'b01, 32'hFFFFFFFF, 32'd2, 32'd3);
    wait_done(lat, ok);
    checks++; if (lat !== 33 || !ok) begin errors++; $display("FAIL mla_timing: got lat=%0d ok=%0d expected 33 1", lat, ok); end
    checks++; if (ResultLo !== 32'h1) begin errors++; $display("FAIL mla_lo: got %h expected 00000001", ResultLo); end
    checks++; if (ResultHi !== 32'h0 || MulFlags !== 2'b00) begin
      errors++; $display("FAIL mla_hi_flags: got hi=%h fl=%b expected 0 00", ResultHi, MulFlags);
    end
  endtask

  task automatic test_long();
    int lat; bit ok;
    logic [1:0]  m [3]  = '{2'b10, 2'b11, 2'b11};
    logic [31:0] a [3]  = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'h80000000};
    logic [31:0] b [3]  = '{32'hFFFFFFFF, 32'h00000003, 32'h80000000};
    logic [31:0] eh [3] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h40000000};
    logic [31:0] el [3] = '{32'h00000001, 32'hFFFFFFFA, 32'h00000000};
    logic [1:0]  ef [3] = '{2'b10, 2'b10, 2'b00};
    for (int i = 0; i < 3; i++) begin
      issue(m[i], a[i], b[i], 32'h0);
      wait_done(lat, ok);
      checks++;
      if (lat !== 33 || ResultHi !== eh[i] || ResultLo !== el[i] || MulFlags !== ef[i]) begin
        errors++;
        $display("FAIL long_%0d: got lat=%0d hi=%h lo=%h fl=%b expected lat=33 hi=%h lo=%h fl=%b",
                 i, lat, ResultHi, ResultLo, MulFlags, eh[i], el[i], ef[i]);
      end
    end
  endtask

  task automatic test_hold();
    bit busy_ok = 1'b1;
    @(negedge clk);
    Start = 1'b1; Mode = 2'b00; SrcA = 32'd7; SrcB = 32'd6; AccIn = 32'd0;
    @(posedge clk);
    repeat (33) begin
      #1;
      if (!Busy) busy_ok = 1'b0;
      Start = 1'b1;
      Mode  = 2'($urandom_range(0, 3));
      SrcA  = $urandom; SrcB = $urandom; AccIn = $urandom;
      @(posedge clk);
    end
    #1;
    checks++; if (!busy_ok) begin errors++; $display("FAIL hold_busy: got busy low during op expected high"); end
    checks++; if (Done !== 1'b1 || Busy !== 1'b0) begin
      errors++; $display("FAIL hold_done: got done=%b busy=%b expected 1 0", Done, Busy);
    end
    checks++; if (ResultLo !== 32'h2A || ResultHi !== 32'h0) begin
      errors++; $display("FAIL hold_result: got hi=%h lo=%h expected 0 0000002a", ResultHi, ResultLo);
    end
    Start = 1'b0;
    @(posedge clk); #1;
    checks++; if (Done !== 1'b0 || Busy !== 1'b0) begin
      errors++; $display("FAIL hold_after: got done=%b busy=%b expected 0 0", Done, Busy);
    end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2; bit ok1, ok2;
    logic [31:0] a1, b1, a2, b2, l1, h1, l2, h2;
    logic [1:0]  f1, f2;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
    model32(2'b10, a1, b1, 32'h0, l1, h1, f1);
    model32(2'b11, a2, b2, 32'h0, l2, h2, f2);
    issue(2'b10, a1, b1, 32'h0);
    wait_done(lat1, ok1);
    Start = 1'b1; Mode = 2'b11; SrcA = a2; SrcB = b2;
    checks++; if (lat1 !== 33 || ResultLo !== l1 || ResultHi !== h1 || MulFlags !== f1) begin
      errors++; $display("FAIL b2b_first: got lat=%0d hi=%h lo=%h fl=%b expected lat=33 hi=%h lo=%h fl=%b",
                         lat1, ResultHi, ResultLo, MulFlags, h1, l1, f1);
    end
    @(posedge clk); #1;
    Start = 1'b0;
    checks++; if (Busy !== 1'b1 || Done !== 1'b0 || ResultLo !== l1) begin
      errors++; $display("FAIL b2b_accept: got busy=%b done=%b lo=%h expected 1 0 %h", Busy, Done, ResultLo, l1);
    end
    wait_done(lat2, ok2);
    checks++; if (lat2 !== 33 || !ok2 || ResultLo !== l2 || ResultHi !== h2 || MulFlags !== f2) begin
      errors++; $display("FAIL b2b_second: got lat=%0d ok=%0d hi=%h lo=%h fl=%b expected lat=33 hi=%h lo=%h fl=%b",
                         lat2, ok2, ResultHi, ResultLo, MulFlags, h2, l2, f2);
    end
  endtask

  task automatic test_reset_mid();
    int lat; bit ok; bit saw_done = 1'b0; bit stayed_zero = 1'b1;
    issue(2'b10, 32'h12345678, 32'h9ABCDEF0, 32'h0);
    repeat (10) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    checks++; if ({ResultLo, ResultHi, MulFlags, Busy, Done} !== 68'd0) begin
      errors++; $display("FAIL reset_mid_clear: got lo=%h hi=%h fl=%b busy=%b done=%b expected all 0",
                         ResultLo, ResultHi, MulFlags, Busy, Done);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (Done) saw_done = 1'b1;
      if (Busy || ResultLo !== 32'h0 || ResultHi !== 32'h0) stayed_zero = 1'b0;
    end
    checks++; if (saw_done || !stayed_zero) begin
      errors++; $display("FAIL reset_mid_abort: got done_seen=%0d zero_kept=%0d expected 0 1", saw_done, stayed_zero);
    end
    issue(2'b00, 32'd0, 32'd5, 32'h0);
    wait_done(lat, ok);
    checks++; if (lat !== 33 || ResultLo !== 32'h0 || MulFlags !== 2'b01) begin
      errors++; $display("FAIL reset_mid_zero: got lat=%0d lo=%h fl=%b expected 33 0 01", lat, ResultLo, MulFlags);
    end
  endtask

  task automatic test_random();
    int lat; bit ok;
    logic [1:0]  m;
    logic [31:0] a, b, c, el, eh;
    logic [1:0]  ef;
    for (int i = 0; i < 30; i++) begin
      m = 2'($urandom_range(0, 3));
      a = pick32(); b = pick32(); c = pick32();
      model32(m, a, b, c, el, eh, ef);
      issue(m, a, b, c);
      wait_done(lat, ok);
      checks++;
      if (lat !== 33 || !ok || ResultLo !== el || ResultHi !== eh || MulFlags !== ef) begin
        errors++;
        $display("FAIL rand_%0d m=%0d a=%h b=%h c=%h: got lat=%0d ok=%0d hi=%h lo=%h fl=%b expected lat=33 hi=%h lo=%h fl=%b",
                 i, m, a, b, c, lat, ok, ResultHi, ResultLo, MulFlags, eh, el, ef);
      end
    end
  endtask

  task automatic test_w8();
    int lat;
    logic [1:0]  m;
    logic [7:0]  a, b, c, el, eh;
    logic [1:0]  ef;
    logic [15:0] p;
    int          sp;
    for (int i = 0; i < 12; i++) begin
      if (i == 0) begin
        m = 2'b10; a = 8'hFF; b = 8'hFF; c = 8'h0;
      end else begin
        m = 2'($urandom_range(0, 3)); a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
      end
      p  = {8'b0, a} * {8'b0, b};
      sp = int'($signed(a)) * int'($signed(b));
      case (m)
        2'b00:   begin el = p[7:0];     eh = '0; end
        2'b01:   begin el = p[7:0] + c; eh = '0; end
        2'b10:   begin el = p[7:0];     eh = p[15:8]; end
        default: begin el = sp[7:0];    eh = sp[15:8]; end
      endcase
      ef = m[1] ? {eh[7], ({eh, el} == 16'd0)} : {el[7], (el == 8'd0)};
      @(negedge clk);
      s8_Start = 1'b1; s8_Mode = m; s8_A = a; s8_B = b; s8_C = c;
      @(posedge clk); #1;
      s8_Start = 1'b0; s8_A = 8'($urandom); s8_B = 8'($urandom);
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
        @(posedge clk); #1;
        if (s8_Done) begin lat = k; break; end
      end
      checks++;
      if (lat !== 9 || s8_Lo !== el || s8_Hi !== eh || s8_Fl !== ef) begin
        errors++;
        $display("FAIL w8_%0d m=%0d a=%h b=%h: got lat=%0d hi=%h lo=%h fl=%b expected lat=9 hi=%h lo=%h fl=%b",
                 i, m, a, b, lat, s8_Hi, s8_Lo, s8_Fl, eh, el, ef);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mla();
    test_long();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_w8();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
